// File: rtl/main_file_cpu_oci_dct_packer.sv
// main_file_cpu_oci_dct_packer: packs 2-bit OCI trace atoms into a 15-atom buffer and
// hands full or flushed buffers to a one-entry packet slot. Optional macro: MAIN_FILE_OCI_DCT_STATS_EN.
`default_nettype none

module main_file_cpu_oci_dct_packer #(
  parameter int ATOM_W  = 2,
  parameter int MAX_CNT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      atom_valid,
  input  logic [ATOM_W-1:0]         atom,
  output logic                      atom_ready,
  input  logic                      flush,
  output logic [MAX_CNT*ATOM_W-1:0] dct_buffer,
  output logic [3:0]                dct_count,
  output logic                      packet_valid,
  output logic [MAX_CNT*ATOM_W-1:0] packet_data,
  output logic [3:0]                packet_count,
  input  logic                      packet_ready,
`ifdef MAIN_FILE_OCI_DCT_STATS_EN
  output logic [15:0]               pkt_sent,
`endif
  output logic                      idle
);

  localparam int         BUF_W   = MAX_CNT * ATOM_W;
  localparam logic [3:0] CNT_MAX = 4'(MAX_CNT);

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e             r_slot;
  logic [BUF_W-1:0]  r_buf;
  logic [3:0]        r_cnt;
  logic [BUF_W-1:0]  r_pkt_data;
  logic [3:0]        r_pkt_cnt;
  logic              r_flush_pend;

  logic              w_accept;
  logic [5:0]        w_shamt;
  logic [BUF_W-1:0]  w_nbuf;
  logic [3:0]        w_ncnt;
  logic              w_pop;
  logic              w_slot_free;
  logic              w_launch;

  assign atom_ready  = (r_cnt != CNT_MAX);
  assign w_accept    = atom_valid && atom_ready;
  assign w_shamt     = 6'(r_cnt) * 6'(ATOM_W);
  // New atom lands just above the ones already held; upper bits stay zero.
  assign w_nbuf      = r_buf | (w_accept ? (BUF_W'(atom) << w_shamt) : '0);
  assign w_ncnt      = r_cnt + {3'b000, w_accept};
  assign w_pop       = (r_slot == SLOT_FULL) && packet_ready;
  assign w_slot_free = (r_slot == SLOT_EMPTY) || packet_ready;
  assign w_launch    = w_slot_free &&
                       ((w_ncnt == CNT_MAX) || ((flush || r_flush_pend) && (w_ncnt != 4'd0)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot       <= SLOT_EMPTY;
      r_buf        <= '0;
      r_cnt        <= 4'd0;
      r_pkt_data   <= '0;
      r_pkt_cnt    <= 4'd0;
      r_flush_pend <= 1'b0;
    end else if (w_launch) begin
      r_slot       <= SLOT_FULL;
      r_pkt_data   <= w_nbuf;
      r_pkt_cnt    <= w_ncnt;
      r_buf        <= '0;
      r_cnt        <= 4'd0;
      r_flush_pend <= 1'b0;
    end else begin
      r_buf <= w_nbuf;
      r_cnt <= w_ncnt;
      if (w_pop) begin
        r_slot <= SLOT_EMPTY;
      end
      // A flush that cannot launch yet is remembered until the slot frees up.
      if (flush && (w_ncnt != 4'd0)) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  assign dct_buffer   = r_buf;
  assign dct_count    = r_cnt;
  assign packet_valid = (r_slot == SLOT_FULL);
  assign packet_data  = r_pkt_data;
  assign packet_count = r_pkt_cnt;
  assign idle         = (r_cnt == 4'd0) && (r_slot == SLOT_EMPTY) && !r_flush_pend;

`ifdef MAIN_FILE_OCI_DCT_STATS_EN
  logic [15:0] r_pkt_sent;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_sent <= 16'd0;
    end else if (w_pop && (r_pkt_sent != 16'hFFFF)) begin
      r_pkt_sent <= r_pkt_sent + 16'd1;
    end
  end

  assign pkt_sent = r_pkt_sent;
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_file_cpu_oci_dct_packer.sv
// Self-checking bench for main_file_cpu_oci_dct_packer: queue-based reference model,
// per-cycle comparison, directed scenarios with literal expectations, then random traffic.
`default_nettype none

module tb_main_file_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom = 2'b00;
  logic        atom_ready;
  logic        flush = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        packet_valid;
  logic [29:0] packet_data;
  logic [3:0]  packet_count;
  logic        packet_ready = 1'b0;
  logic        idle;
`ifdef MAIN_FILE_OCI_DCT_STATS_EN
  logic [15:0] pkt_sent;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  main_file_cpu_oci_dct_packer dut (
    .clk          (clk),
    .reset        (reset),
    .atom_valid   (atom_valid),
    .atom         (atom),
    .atom_ready   (atom_ready),
    .flush        (flush),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .packet_valid (packet_valid),
    .packet_data  (packet_data),
    .packet_count (packet_count),
    .packet_ready (packet_ready),
`ifdef MAIN_FILE_OCI_DCT_STATS_EN
    .pkt_sent     (pkt_sent),
`endif
    .idle         (idle)
  );

  // Reference model: atoms held as a queue, packet slot as a list snapshot.
  int          m_q[$];
  bit          m_pv;
  logic [29:0] m_pdata;
  int          m_pcnt;
  bit          m_pend;
  int          m_pops;

  function automatic logic [29:0] pack_atoms(input int q[$]);
    logic [29:0] v = '0;
    for (int i = 0; i < q.size(); i++) v = v + (30'(q[i]) << (2 * i));
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_pv = 0; m_pdata = '0; m_pcnt = 0; m_pend = 0; m_pops = 0;
    end else begin
      bit pop, launch, can_take;
      can_take = (m_q.size() != 15);
      if (atom_valid && can_take) m_q.push_back(int'(atom));
      pop = m_pv && packet_ready;
      if (pop) m_pops++;
      launch = (!m_pv || packet_ready) &&
               (m_q.size() == 15 || ((flush || m_pend) && m_q.size() != 0));
      if (launch) begin
        m_pv = 1; m_pdata = pack_atoms(m_q); m_pcnt = m_q.size();
        m_q.delete(); m_pend = 0;
      end else begin
        if (pop) m_pv = 0;
        if (flush && m_q.size() != 0) m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("dct_count", 32'(dct_count), 32'(m_q.size()));
      check("dct_buffer", 32'(dct_buffer), 32'(pack_atoms(m_q)));
      check("atom_ready", 32'(atom_ready), 32'(m_q.size() != 15));
      check("packet_valid", 32'(packet_valid), 32'(m_pv));
      if (m_pv) begin
        check("packet_data", 32'(packet_data), 32'(m_pdata));
        check("packet_count", 32'(packet_count), 32'(m_pcnt));
      end
      check("idle", 32'(idle), 32'(m_q.size() == 0 && !m_pv && !m_pend));
`ifdef MAIN_FILE_OCI_DCT_STATS_EN
      check("pkt_sent", 32'(pkt_sent), (m_pops > 65535) ? 32'hFFFF : 32'(m_pops));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) begin
      atom_valid = 1'b1; atom = a;
      tick();
    end
    atom_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_count", 32'(dct_count), 32'd0);
    check("rst_ready", 32'(atom_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);

    // 15 atoms of 01 with consumer ready
    packet_ready = 1'b1;
    feed(15, 2'b01);
    check("full_valid", 32'(packet_valid), 32'd1);
    check("full_data", 32'(packet_data), 32'h15555555);
    check("full_count", 32'(packet_count), 32'd15);
    check("full_dct_count", 32'(dct_count), 32'd0);
    tick();
    check("full_popped", 32'(packet_valid), 32'd0);

    // 11,10,01 then flush
    feed(1, 2'b11); feed(1, 2'b10); feed(1, 2'b01);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_data", 32'(packet_data), 32'h0000001B);
    check("flush_count", 32'(packet_count), 32'd3);
    tick();

    // backpressure: 30 atoms with consumer stalled
    packet_ready = 1'b0;
    feed(15, 2'b11);
    feed(15, 2'b10);
    check("bp_held_data", 32'(packet_data), 32'h3FFFFFFF);
    check("bp_dct_count", 32'(dct_count), 32'd15);
    check("bp_atom_ready", 32'(atom_ready), 32'd0);
    feed(3, 2'b01);
    check("bp_no_drop", 32'(dct_buffer), 32'h2AAAAAAA);
    packet_ready = 1'b1; tick(); packet_ready = 1'b0;
    check("b2b_valid", 32'(packet_valid), 32'd1);
    check("b2b_data", 32'(packet_data), 32'h2AAAAAAA);
    check("b2b_dct_count", 32'(dct_count), 32'd0);
    packet_ready = 1'b1; tick();

    // flush with nothing held
    flush = 1'b1; tick(); flush = 1'b0;
    check("empty_flush_valid", 32'(packet_valid), 32'd0);
    check("empty_flush_idle", 32'(idle), 32'd1);

    // flush while slot busy with 4 atoms held
    packet_ready = 1'b0;
    feed(15, 2'b01);
    feed(2, 2'b10); feed(2, 2'b11);
    flush = 1'b1; tick(); flush = 1'b0;
    check("pend_count", 32'(dct_count), 32'd4);
    check("pend_idle", 32'(idle), 32'd0);
    tick();
    packet_ready = 1'b1; tick();
    check("pend_launch_valid", 32'(packet_valid), 32'd1);
    check("pend_launch_count", 32'(packet_count), 32'd4);
    check("pend_launch_data", 32'(packet_data), 32'h000000FA);
    check("pend_dct_count", 32'(dct_count), 32'd0);
    tick();

    // asynchronous reset mid-fill with slot occupied
    packet_ready = 1'b0;
    feed(15, 2'b10);
    feed(7, 2'b11);
    check("pre_rst_count", 32'(dct_count), 32'd7);
    #2 reset = 1'b1;
    #1;
    check("arst_count", 32'(dct_count), 32'd0);
    check("arst_buffer", 32'(dct_buffer), 32'd0);
    check("arst_valid", 32'(packet_valid), 32'd0);
    check("arst_data", 32'(packet_data), 32'd0);
    check("arst_pcount", 32'(packet_count), 32'd0);
    check("arst_ready", 32'(atom_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      atom_valid   = ($urandom_range(0, 3) != 0);
      atom         = 2'($urandom);
      flush        = ($urandom_range(0, 15) == 0);
      packet_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    atom_valid = 1'b0; flush = 1'b0; packet_ready = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
